// File: rtl/booth_pkg.sv
// Shared types and operation encodings for the sequential Booth multiplier datapath.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    // booth_op = {Q[0], Q(-1)}; both 00 and 11 mean "shift only".
    localparam logic [1:0] BOOTH_NOP  = 2'b00;
    localparam logic [1:0] BOOTH_NOP2 = 2'b11;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;

endpackage

// File: rtl/booth_dff_vec.sv
// Parametrised enable register with asynchronous active-high clear; the storage
// cell used for every datapath register of booth_shift_reg.
module booth_dff_vec #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/booth_shift_reg.sv
// {A,Q,q_m1} shift chain, step counter and IDLE/RUN/DONE control for the Booth multiplier.
// Optional synchronous clear port sclr when BOOTH_SHIFT_REG_SCLR_EN is defined.
module booth_shift_reg
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEPS = WIDTH,
    parameter int CW    = $clog2(STEPS + 1)
) (
    input  logic             clk,
    input  logic             clr,
`ifdef BOOTH_SHIFT_REG_SCLR_EN
    input  logic             sclr,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] q_init,
    input  logic             step_en,
    input  logic             a_we,
    input  logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q_m1,
    output logic [1:0]       booth_op,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done
);

    booth_state_t     state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, q_q, q_d, a_sel;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             reg_en;
    logic             step;
    logic             last_step;
    logic             sclr_w;

`ifdef BOOTH_SHIFT_REG_SCLR_EN
    assign sclr_w = sclr;
`else
    assign sclr_w = 1'b0;
`endif

    assign step      = (state_q == RUN) && step_en;
    assign last_step = (cnt_q == CW'(STEPS - 1));
    assign a_sel     = a_we ? a_in : a_q;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        reg_en = 1'b0;
        a_d    = a_q;
        q_d    = q_q;
        qm1_d  = qm1_q;
        cnt_d  = cnt_q;
        if (sclr_w) begin
            reg_en = 1'b1;
            a_d    = '0;
            q_d    = '0;
            qm1_d  = 1'b0;
            cnt_d  = '0;
        end else if (load) begin
            reg_en = 1'b1;
            a_d    = '0;
            q_d    = q_init;
            qm1_d  = 1'b0;
            cnt_d  = '0;
        end else if (step) begin
            // Arithmetic shift right of the whole {A',Q,q_m1} chain.
            reg_en = 1'b1;
            a_d    = {a_sel[WIDTH-1], a_sel[WIDTH-1:1]};
            q_d    = {a_sel[0], q_q[WIDTH-1:1]};
            qm1_d  = q_q[0];
            cnt_d  = cnt_q + CW'(1);
        end
    end

    booth_dff_vec #(.WIDTH(WIDTH)) u_a_reg (
        .clk (clk), .clr (clr), .en (reg_en), .d (a_d), .q (a_q)
    );

    booth_dff_vec #(.WIDTH(WIDTH)) u_q_reg (
        .clk (clk), .clr (clr), .en (reg_en), .d (q_d), .q (q_q)
    );

    booth_dff_vec #(.WIDTH(1)) u_qm1_reg (
        .clk (clk), .clr (clr), .en (reg_en), .d (qm1_d), .q (qm1_q)
    );

    booth_dff_vec #(.WIDTH(CW)) u_cnt_reg (
        .clk (clk), .clr (clr), .en (reg_en), .d (cnt_d), .q (cnt_q)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sclr_w) begin
            state_d = IDLE;
        end else if (load) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = (step && last_step) ? DONE : RUN;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    assign a_out    = a_q;
    assign q_out    = q_q;
    assign q_m1     = qm1_q;
    assign count    = cnt_q;
    assign booth_op = {q_q[0], qm1_q};

endmodule

// File: tb/tb_booth_shift_reg.sv
// Randomised self-checking bench for booth_shift_reg (WIDTH=4) against an
// arithmetic model of the {A,Q,q_m1} chain and signed-product expectations.
module tb_booth_shift_reg;

    localparam int W  = 4;
    localparam int S  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          clr;
    logic          sclr;
    logic          load;
    logic [W-1:0]  q_init;
    logic          step_en;
    logic          a_we;
    logic [W-1:0]  a_in;
    logic [W-1:0]  a_out;
    logic [W-1:0]  q_out;
    logic          q_m1;
    logic [1:0]    booth_op;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    // Reference model: registers as plain values, state as 0=idle 1=run 2=done.
    logic [W-1:0] m_a, m_q;
    logic         m_qm1;
    int           m_cnt;
    int           m_st;

    logic [15:0] dut_vec;
    assign dut_vec = {a_out, q_out, q_m1, count, busy, done, booth_op};

    booth_shift_reg #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
`ifdef BOOTH_SHIFT_REG_SCLR_EN
        .sclr     (sclr),
`endif
        .load     (load),
        .q_init   (q_init),
        .step_en  (step_en),
        .a_we     (a_we),
        .a_in     (a_in),
        .a_out    (a_out),
        .q_out    (q_out),
        .q_m1     (q_m1),
        .booth_op (booth_op),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_a   = '0;
        m_q   = '0;
        m_qm1 = 1'b0;
        m_cnt = 0;
        m_st  = 0;
    endfunction

    function automatic void model_edge();
        logic [W-1:0]       ap;
        logic signed [2*W:0] ch;
        if (sclr) begin
            model_reset();
        end else if (load) begin
            m_a = '0; m_q = q_init; m_qm1 = 1'b0; m_cnt = 0; m_st = 1;
        end else if (m_st == 2) begin
            m_st = 0;
        end else if (m_st == 1 && step_en) begin
            ap = a_we ? a_in : m_a;
            ch = {ap, m_q, m_qm1};
            ch = ch >>> 1;
            {m_a, m_q, m_qm1} = ch;
            m_cnt++;
            if (m_cnt == S) m_st = 2;
        end
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_a, m_q, m_qm1, 3'(m_cnt), (m_st == 1), (m_st == 2), m_q[0], m_qm1};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Behaves as the external add/sub unit, decoding the model's own Booth pair.
    task automatic drive_booth(input logic [W-1:0] m, input bit en);
        step_en = en;
        a_we    = 1'b0;
        a_in    = W'($urandom);
        if ({m_q[0], m_qm1} == 2'b01) begin
            a_we = 1'b1; a_in = m_a + m;
        end else if ({m_q[0], m_qm1} == 2'b10) begin
            a_we = 1'b1; a_in = m_a - m;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (dut_vec !== 16'h0) begin
            errors++;
            $display("FAIL reset_initial: got %h expected %h", dut_vec, 16'h0);
        end
        clr = 1'b0;
        load = 1'b1; q_init = W'($urandom); tick(); load = 1'b0;
        drive_booth(4'b0011, 1'b1); tick();
        drive_booth(4'b0011, 1'b1); tick();
        step_en = 1'b0;
        #2 clr = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_midrun: got %h expected %h", dut_vec, 16'h0);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_en = 1'b1; a_we = 1'b1; a_in = W'($urandom);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle_ignores_step: got %h expected %h", dut_vec, exp_vec());
            end
        end
        step_en = 1'b0; a_we = 1'b0;
    endtask

    task automatic test_load();
        load = 1'b1; q_init = 4'b0011; tick(); load = 1'b0;
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL load_state: got %h expected %h", dut_vec, exp_vec());
        end
        checks++;
        if (q_out !== 4'b0011 || a_out !== 4'b0000 || booth_op !== 2'b10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_fields: got q=%b a=%b op=%b busy=%b expected q=0011 a=0000 op=10 busy=1",
                     q_out, a_out, booth_op, busy);
        end
    endtask

    task automatic test_single_step();
        step_en = 1'b1; a_we = 1'b1; a_in = 4'b0101; tick();
        step_en = 1'b0; a_we = 1'b0;
        checks++;
        if ({a_out, q_out, q_m1, count} !== {4'b0010, 4'b1001, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL single_step: got a=%b q=%b qm1=%b cnt=%0d expected a=0010 q=1001 qm1=1 cnt=1",
                     a_out, q_out, q_m1, count);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL single_step_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] qv, input bit stalls);
        int          guard;
        int          p;
        logic [7:0]  prod;
        load = 1'b1; q_init = qv; step_en = 1'b0; tick(); load = 1'b0;
        guard = 0;
        while (m_st == 1 && guard < 40) begin
            drive_booth(m, stalls ? bit'($urandom_range(0, 1)) : 1'b1);
            tick();
            guard++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL mul_cycle m=%h q=%h: got %h expected %h", m, qv, dut_vec, exp_vec());
            end
        end
        p    = int'($signed(m)) * int'($signed(qv));
        prod = p[7:0];
        checks++;
        if ({a_out, q_out} !== prod || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_product m=%h q=%h: got %h done=%b busy=%b expected %h done=1 busy=0",
                     m, qv, {a_out, q_out}, done, busy, prod);
        end
        for (int i = 0; i < 2; i++) begin
            step_en = 1'b1; a_we = 1'b1; a_in = W'($urandom);
            tick();
            checks++;
            if (dut_vec !== exp_vec() || {a_out, q_out} !== prod || count !== 3'(S)) begin
                errors++;
                $display("FAIL mul_hold m=%h q=%h: got %h expected %h", m, qv, dut_vec, exp_vec());
            end
        end
        step_en = 1'b0; a_we = 1'b0;
    endtask

    task automatic test_mul_fixed();
        run_mul(4'b1011, 4'b0011, 1'b0);
        checks++;
        if ({a_out, q_out} !== 8'hF1) begin
            errors++;
            $display("FAIL mul_3x_m5: got %h expected f1", {a_out, q_out});
        end
    endtask

    task automatic test_mul_random();
        logic [W-1:0] m;
        for (int i = 0; i < 8; i++) begin
            m = W'($urandom_range(0, 15));
            if (m == 4'b1000) m = 4'b0111;
            run_mul(m, W'($urandom), 1'b1);
        end
    endtask

    task automatic test_restart_stall();
        logic [W-1:0] m, qn;
        m = W'($urandom_range(1, 7));
        load = 1'b1; q_init = W'($urandom); tick(); load = 1'b0;
        drive_booth(m, 1'b1); tick();
        drive_booth(m, 1'b1); tick();
        qn = W'($urandom);
        load = 1'b1; q_init = qn; step_en = 1'b1; a_we = 1'b1; a_in = W'($urandom);
        tick();
        load = 1'b0;
        checks++;
        if (count !== 3'd0 || q_out !== qn || a_out !== 4'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: got cnt=%0d q=%h a=%h busy=%b expected cnt=0 q=%h a=0 busy=1",
                     count, q_out, a_out, busy, qn);
        end
        drive_booth(m, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            step_en = 1'b0; a_we = 1'b1; a_in = W'($urandom);
            tick();
            checks++;
            if (dut_vec !== exp_vec() || count !== 3'd1) begin
                errors++;
                $display("FAIL stall: got %h expected %h", dut_vec, exp_vec());
            end
        end
        a_we = 1'b0;
    endtask

    task automatic test_sclr();
`ifdef BOOTH_SHIFT_REG_SCLR_EN
        load = 1'b1; q_init = W'($urandom_range(1, 15)); tick(); load = 1'b0;
        drive_booth(4'b0101, 1'b1); tick();
        sclr = 1'b1; load = 1'b1; step_en = 1'b1;
        tick();
        sclr = 1'b0; load = 1'b0; step_en = 1'b0;
        checks++;
        if (dut_vec !== 16'h0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL sclr_over_load: got %h expected %h", dut_vec, 16'h0);
        end
`endif
    endtask

    initial begin
        clr = 1'b1; sclr = 1'b0; load = 1'b0; q_init = '0;
        step_en = 1'b0; a_we = 1'b0; a_in = '0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_load();
        test_single_step();
        test_mul_fixed();
        test_mul_random();
        test_restart_stall();
        test_sclr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
